// File: rtl/cmp_pkg.sv
// cmp_pkg: shared tag encoding, packer states and payload-length helper for stream_compressor.
package cmp_pkg;
  localparam int TAG_WIDTH = 2;
  localparam int unsigned SMALL_WIDTH = 8;
  typedef enum logic [TAG_WIDTH-1:0] {
    TAG_ZERO   = 2'b00,
    TAG_REPEAT = 2'b01,
    TAG_SMALL  = 2'b10,
    TAG_RAW    = 2'b11
  } tag_e;
  typedef enum logic {ACCUM, FLUSH} pack_state_e;
  function automatic int unsigned payload_len(tag_e tag, int unsigned data_width);
    return tag == TAG_RAW ? data_width : tag == TAG_SMALL ? SMALL_WIDTH : 32'd0;
  endfunction
endpackage

// File: rtl/stream_compressor_if.sv
// stream_compressor_if: input and output AXI-stream signals of the compressor.
//   mode/s_tdata/s_tvalid/s_tlast/s_tready : input stream and per-packet mode
//   m_tdata/m_tvalid/m_tlast/m_tbits/m_tready : packed output stream
//   slave modport is the compressor's view, master is the driver/sink view.
interface stream_compressor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA = 8,
  parameter int LEN_WIDTH = $clog2(2*DATA_WIDTH*NUM_DATA+2*NUM_DATA)+1
);
  localparam int OUT_W = DATA_WIDTH*NUM_DATA;
  logic mode;
  logic [OUT_W-1:0] s_tdata;
  logic s_tvalid;
  logic s_tlast;
  logic s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic m_tvalid;
  logic m_tlast;
  logic [LEN_WIDTH-1:0] m_tbits;
  logic m_tready;
  modport master (
    output mode, s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tbits
  );
  modport slave (
    input  mode, s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tbits
  );
endinterface

// File: rtl/cmp_bit_packer.sv
// cmp_bit_packer: appends variable-length records LSB-first into a bit buffer and emits fixed OUT_W beats.
//   clk, reset (async active-low)
//   rec_valid/rec/rec_len/rec_last/rec_ready : record handshake from the encode stage
//   m_tdata/m_tvalid/m_tlast/m_tbits/m_tready : registered output beat
module cmp_bit_packer
  import cmp_pkg::*;
#(
  parameter int OUT_W = 256,
  parameter int REC_W = 272,
  parameter int LEN_WIDTH = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic rec_valid,
  input  logic [REC_W-1:0] rec,
  input  logic [LEN_WIDTH-1:0] rec_len,
  input  logic rec_last,
  output logic rec_ready,
  output logic [OUT_W-1:0] m_tdata,
  output logic m_tvalid,
  output logic m_tlast,
  output logic [LEN_WIDTH-1:0] m_tbits,
  input  logic m_tready
);
  localparam int BUF_W = OUT_W + REC_W;
  pack_state_e state, state_next;
  logic [BUF_W-1:0] data_buf, buf_shift, buf_next;
  logic [LEN_WIDTH-1:0] fill, fill_emit, fill_next;
  logic out_free, emit, last_beat;
  // Bits above fill are always zero, so a partial final beat is zero-padded for free.
  always_comb begin
    out_free = !m_tvalid || m_tready;
    last_beat = state == FLUSH && fill <= LEN_WIDTH'(OUT_W);
    emit = out_free && (state == FLUSH ? fill != '0 : fill >= LEN_WIDTH'(OUT_W));
    fill_emit = !emit ? fill : last_beat ? '0 : fill - LEN_WIDTH'(OUT_W);
    rec_ready = state == ACCUM && rec_valid && fill_emit < LEN_WIDTH'(OUT_W);
    buf_shift = !emit ? data_buf : last_beat ? '0 : data_buf >> OUT_W;
    buf_next = rec_ready ? buf_shift | (BUF_W'(rec) << fill_emit) : buf_shift;
    fill_next = rec_ready ? fill_emit + rec_len : fill_emit;
    state_next = rec_ready && rec_last ? FLUSH : emit && last_beat ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
      data_buf <= '0;
      fill <= '0;
      m_tdata <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      m_tbits <= '0;
    end else begin
      state <= state_next;
      data_buf <= buf_next;
      fill <= fill_next;
      if (emit) begin
        m_tdata <= data_buf[OUT_W-1:0];
        m_tvalid <= 1'b1;
        m_tlast <= last_beat;
        m_tbits <= last_beat ? fill : LEN_WIDTH'(OUT_W);
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/stream_compressor.sv
// stream_compressor: tags each word of an N-word beat (zero/repeat/small/raw) and packs the records into fixed beats.
//   clk, reset (async active-low)
//   bus : stream_compressor_if slave (mode, s_* input stream, m_* packed output stream)
module stream_compressor
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA = 8,
  parameter int LEN_WIDTH = $clog2(2*DATA_WIDTH*NUM_DATA+2*NUM_DATA)+1
) (
  input logic clk,
  input logic reset,
  stream_compressor_if.slave bus
);
  localparam int OUT_W = DATA_WIDTH*NUM_DATA;
  localparam int REC_W = OUT_W + TAG_WIDTH*NUM_DATA;
  logic first, mode_q, mode_eff, in_fire;
  logic [DATA_WIDTH-1:0] prev_q, w, p;
  logic [REC_W-1:0] enc_rec, rec;
  logic [LEN_WIDTH-1:0] pos, rec_len;
  logic rec_valid, rec_last, rec_ready;
  tag_e tag;
  // The mode pin is only honoured on a packet's first beat; later beats reuse the latch.
  assign mode_eff = first ? bus.mode : mode_q;
  assign bus.s_tready = !rec_valid || rec_ready;
  assign in_fire = bus.s_tvalid && bus.s_tready;
  // Tags fill the low 2N bits; payloads follow in word order at a running bit offset.
  always_comb begin
    enc_rec = '0;
    pos = LEN_WIDTH'(TAG_WIDTH*NUM_DATA);
    p = first ? '0 : prev_q;
    w = '0;
    tag = TAG_ZERO;
    for (int i = 0; i < NUM_DATA; i++) begin
      w = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      tag = w == '0 ? TAG_ZERO : w == p ? TAG_REPEAT : w < DATA_WIDTH'(256) ? TAG_SMALL : TAG_RAW;
      enc_rec[i*TAG_WIDTH +: TAG_WIDTH] = tag;
      enc_rec = enc_rec | (REC_W'(tag[1] ? w : '0) << pos);
      pos = pos + LEN_WIDTH'(payload_len(tag, DATA_WIDTH));
      p = w;
    end
    enc_rec = mode_eff ? enc_rec : REC_W'(bus.s_tdata);
    pos = mode_eff ? pos : LEN_WIDTH'(OUT_W);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first <= 1'b1;
      mode_q <= 1'b1;
      prev_q <= '0;
      rec_valid <= 1'b0;
      rec <= '0;
      rec_len <= '0;
      rec_last <= 1'b0;
    end else if (in_fire) begin
      first <= bus.s_tlast;
      mode_q <= mode_eff;
      prev_q <= bus.s_tdata[(NUM_DATA-1)*DATA_WIDTH +: DATA_WIDTH];
      rec_valid <= 1'b1;
      rec <= enc_rec;
      rec_len <= pos;
      rec_last <= bus.s_tlast;
    end else if (rec_ready) begin
      rec_valid <= 1'b0;
    end
  end
  cmp_bit_packer #(.OUT_W(OUT_W), .REC_W(REC_W), .LEN_WIDTH(LEN_WIDTH)) u_packer (
    .clk(clk),
    .reset(reset),
    .rec_valid(rec_valid),
    .rec(rec),
    .rec_len(rec_len),
    .rec_last(rec_last),
    .rec_ready(rec_ready),
    .m_tdata(bus.m_tdata),
    .m_tvalid(bus.m_tvalid),
    .m_tlast(bus.m_tlast),
    .m_tbits(bus.m_tbits),
    .m_tready(bus.m_tready)
  );
endmodule

// File: tb/tb_stream_compressor.sv
// tb_stream_compressor: directed and random packets checked against a bit-stream reference model.
module tb_stream_compressor;
  localparam int DW = 32;
  localparam int N = 8;
  localparam int OUT_W = DW*N;
  localparam int LW = $clog2(2*OUT_W+2*N)+1;
  typedef logic [OUT_W-1:0] beat_w;
  typedef struct {
    beat_w data;
    int bits;
    bit last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int last_bits = 0;
  bit ready_rand = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  beat_w pkt[$];
  logic [DW-1:0] last_word = '0;
  always #5 clk = ~clk;
  stream_compressor_if #(.DATA_WIDTH(DW), .NUM_DATA(N), .LEN_WIDTH(LW)) bus ();
  stream_compressor #(.DATA_WIDTH(DW), .NUM_DATA(N), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input beat_w got, input beat_w want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  // Reference: build the packet's whole bit stream, then cut it into OUT_W beats.
  task automatic model_packet(input bit md);
    bit s[$];
    logic [DW-1:0] p, w;
    logic [DW-1:0] pay[$];
    int plen[$];
    int tag, len;
    exp_t b;
    p = '0;
    foreach (pkt[k]) begin
      if (!md) begin
        for (int j = 0; j < OUT_W; j++) s.push_back(pkt[k][j]);
      end else begin
        pay.delete();
        plen.delete();
        for (int i = 0; i < N; i++) begin
          w = pkt[k][i*DW +: DW];
          if (w == 0) begin tag = 0; len = 0; end
          else if (w == p) begin tag = 1; len = 0; end
          else if (w < 256) begin tag = 2; len = 8; end
          else begin tag = 3; len = DW; end
          s.push_back(tag[0]);
          s.push_back(tag[1]);
          pay.push_back(w);
          plen.push_back(len);
          p = w;
        end
        for (int i = 0; i < N; i++)
          for (int j = 0; j < plen[i]; j++) s.push_back(pay[i][j]);
      end
    end
    while (s.size() > 0) begin
      b.data = '0;
      b.bits = 0;
      while (b.bits < OUT_W && s.size() > 0) begin
        b.data[b.bits] = s.pop_front();
        b.bits++;
      end
      b.last = s.size() == 0;
      exp_q.push_back(b);
    end
  endtask
  task automatic wait_accept();
    int n = 0;
    bit acc = 1'b0;
    do begin
      @(negedge clk);
      acc = bus.s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout: observed s_tready=0 for %0d cycles, expected 1", n);
    end
  endtask
  task automatic send_packet(input bit md, input bit toggle);
    model_packet(md);
    foreach (pkt[k]) begin
      bus.s_tdata = pkt[k];
      bus.s_tvalid = 1'b1;
      bus.s_tlast = k == pkt.size() - 1;
      bus.mode = (k == 0 || !toggle) ? md : !md;
      wait_accept();
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask
  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_tvalid && n < 100);
    chk("out_timeout", beat_w'(bus.m_tvalid), beat_w'(1));
  endtask
  task automatic gen_beat(output beat_w b);
    int unsigned r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 3);
      last_word = r == 0 ? '0 : r == 1 ? last_word : r == 2 ? DW'($urandom_range(1, 255)) : DW'($urandom);
      b[i*DW +: DW] = last_word;
    end
  endtask
  task automatic gen_raw(output beat_w b);
    logic [DW-1:0] w;
    for (int i = 0; i < N; i++) begin
      w = DW'($urandom) | 32'h100;
      if (w == last_word) w = w ^ 32'h1000_0000;
      b[i*DW +: DW] = w;
      last_word = w;
    end
  endtask
  always @(negedge clk) begin
    if (bus.s_tvalid && !bus.s_tready) stalls++;
    if (reset && bus.m_tvalid && bus.m_tready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL out_unexpected: observed beat %h expected none", bus.m_tdata);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("out_data", bus.m_tdata, mon_e.data);
        chk("out_bits", beat_w'(bus.m_tbits), beat_w'(mon_e.bits));
        chk("out_last", beat_w'(bus.m_tlast), beat_w'(mon_e.last));
        if (bus.m_tlast) last_bits = int'(bus.m_tbits);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_rand) bus.m_tready = $urandom_range(0, 3) != 0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    beat_w b, held;
    bit have;
    int st0;
    bus.mode = 1'b1;
    bus.s_tdata = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tready", beat_w'(bus.s_tready), beat_w'(1));
    chk("rst_tvalid", beat_w'(bus.m_tvalid), beat_w'(0));
    chk("rst_tlast", beat_w'(bus.m_tlast), beat_w'(0));
    chk("rst_tdata", bus.m_tdata, '0);
    chk("rst_tbits", beat_w'(bus.m_tbits), beat_w'(0));
    @(posedge clk);
    #1;
    // all-zero beat
    pkt = {beat_w'(0)};
    send_packet(1'b1, 1'b0);
    wait_out();
    chk("zero_bits", beat_w'(bus.m_tbits), beat_w'(16));
    chk("zero_last", beat_w'(bus.m_tlast), beat_w'(1));
    chk("zero_data", bus.m_tdata, '0);
    drain();
    // repeat and small words
    b = '0;
    b[31:0] = 32'h1234_5678;
    b[63:32] = 32'h1234_5678;
    b[95:64] = 32'h5;
    pkt = {b};
    send_packet(1'b1, 1'b0);
    wait_out();
    chk("rep_bits", beat_w'(bus.m_tbits), beat_w'(56));
    chk("rep_data", bus.m_tdata, beat_w'(64'h0005_1234_5678_0027));
    drain();
    // bypass with mode toggled mid-packet
    pkt.delete();
    repeat (3) begin
      gen_beat(b);
      pkt.push_back(b);
    end
    send_packet(1'b0, 1'b1);
    drain();
    // worst case: raw words only
    last_bits = 0;
    pkt.delete();
    last_word = '0;
    repeat (4) begin
      gen_raw(b);
      pkt.push_back(b);
    end
    send_packet(1'b1, 1'b0);
    drain();
    chk("worst_last_bits", beat_w'(last_bits), beat_w'(64));
    // backpressure for 20 cycles
    pkt.delete();
    repeat (6) begin
      gen_raw(b);
      pkt.push_back(b);
    end
    st0 = stalls;
    have = 1'b0;
    bus.m_tready = 1'b0;
    fork
      send_packet(1'b1, 1'b0);
      begin
        repeat (20) begin
          @(negedge clk);
          if (bus.m_tvalid) begin
            if (have) chk("bp_stable", bus.m_tdata, held);
            held = bus.m_tdata;
            have = 1'b1;
          end
        end
        chk("bp_valid_seen", beat_w'(have), beat_w'(1));
        chk("bp_stalled", beat_w'(stalls > st0), beat_w'(1));
        @(posedge clk);
        #1;
        bus.m_tready = 1'b1;
      end
    join
    drain();
    // reset in the middle of a packet (96 bits buffered)
    b = '0;
    b[31:0] = 32'd3;
    b[63:32] = 32'd4;
    b[223:192] = 32'hCAFE_0001;
    b[255:224] = 32'hDEAD_BEEF;
    bus.s_tdata = b;
    bus.s_tvalid = 1'b1;
    bus.s_tlast = 1'b0;
    bus.mode = 1'b1;
    wait_accept();
    bus.s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", beat_w'(bus.m_tvalid), beat_w'(0));
    chk("mid_rst_tready", beat_w'(bus.s_tready), beat_w'(1));
    chk("mid_rst_tbits", beat_w'(bus.m_tbits), beat_w'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    b = '0;
    b[31:0] = 32'hDEAD_BEEF;
    b[63:32] = 32'hDEAD_BEEF;
    pkt = {b};
    send_packet(1'b1, 1'b0);
    drain();
    // random packets, back-to-back, random downstream ready
    ready_rand = 1'b1;
    repeat (15) begin
      pkt.delete();
      repeat ($urandom_range(1, 4)) begin
        gen_beat(b);
        pkt.push_back(b);
      end
      send_packet($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    drain();
    ready_rand = 1'b0;
    @(posedge clk);
    #1;
    bus.m_tready = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
